// File: rtl/ula_multiciclo.sv
// Registered-output ALU for the multicycle datapath: single-cycle logic/arith/shift ops,
// plus iterative shift-add multiply and restoring divide, one step per clock.
module ula_multiciclo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ULAControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ULAResult,
  output logic             Z
);
  localparam int SHW = $clog2(WIDTH);

  // state | meaning
  // IDLE  | waiting for start; single-cycle ops complete here
  // CALC  | iterating mul/div, one step per cycle for WIDTH cycles
  typedef enum logic {IDLE, CALC} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
  logic [SHW-1:0]   cnt_q;
  logic             op_div, op_hi;

  logic [WIDTH-1:0] alu_single;
  logic [SHW-1:0]   shamt;
  logic             is_iter;

  assign shamt   = SrcB[SHW-1:0];
  assign is_iter = (ULAControl >= 4'b1010) && (ULAControl <= 4'b1101);

  always_comb begin
    alu_single = '0;
    case (ULAControl)
      4'b0000: alu_single = SrcA + SrcB;
      4'b0001: alu_single = SrcA - SrcB;
      4'b0010: alu_single = SrcA & SrcB;
      4'b0011: alu_single = SrcA | SrcB;
      4'b0100: alu_single = SrcA ^ SrcB;
      4'b0101: alu_single[0] = $signed(SrcA) < $signed(SrcB);
      4'b0110: alu_single[0] = SrcA < SrcB;
      4'b0111: alu_single = SrcA << shamt;
      4'b1000: alu_single = SrcA >> shamt;
      4'b1001: alu_single = $unsigned($signed(SrcA) >>> shamt);
      default: alu_single = '0;
    endcase
  end

  // Multiply: {hi,lo} holds partial product with the multiplier shifting out of lo.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
  assign mul_hi  = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};

  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
  // A zero divisor always "fits", giving an all-ones quotient and remainder = dividend.
  logic [WIDTH:0]   div_sh;
  logic [WIDTH-1:0] div_sub, div_hi, div_lo;
  logic             div_ok;
  assign div_sh  = {hi_q, lo_q[WIDTH-1]};
  assign div_ok  = div_sh[WIDTH] | (div_sh[WIDTH-1:0] >= b_q);
  assign div_sub = div_sh[WIDTH-1:0] - b_q;
  assign div_hi  = div_ok ? div_sub : div_sh[WIDTH-1:0];
  assign div_lo  = {lo_q[WIDTH-2:0], div_ok};

  logic [WIDTH-1:0] nxt_hi, nxt_lo, iter_res;
  assign nxt_hi   = op_div ? div_hi : mul_hi;
  assign nxt_lo   = op_div ? div_lo : mul_lo;
  assign iter_res = op_hi ? nxt_hi : nxt_lo;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ULAResult <= '0;
      Z         <= 1'b1;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      op_div    <= 1'b0;
      op_hi     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_iter) begin
              state  <= CALC;
              busy   <= 1'b1;
              a_q    <= SrcA;
              b_q    <= SrcB;
              hi_q   <= '0;
              lo_q   <= ULAControl[2] ? SrcA : SrcB;
              op_div <= ULAControl[2];
              op_hi  <= ULAControl[0];
              cnt_q  <= '0;
            end else begin
              ULAResult <= alu_single;
              Z         <= (alu_single == '0);
              done      <= 1'b1;
            end
          end
        end
        CALC: begin
          hi_q  <= nxt_hi;
          lo_q  <= nxt_lo;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == SHW'(WIDTH - 1)) begin
            ULAResult <= iter_res;
            Z         <= (iter_res == '0);
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
            cnt_q     <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ula_multiciclo.sv
// Directed vector table plus hand-written multicycle sequences for ula_multiciclo.
module tb_ula_multiciclo;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  ULAControl = 4'b0;
  logic [31:0] SrcA = '0, SrcB = '0;
  logic        busy, done, Z;
  logic [31:0] ULAResult;

  int total = 0;
  int bad = 0;

  ula_multiciclo #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .ULAControl(ULAControl),
    .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done),
    .ULAResult(ULAResult), .Z(Z)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Launch one op and wait (bounded) for done; reports latency and busy-cycle count.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1'b1; ULAControl = op; SrcA = a; SrcB = b;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, bc, ndone, dcyc;
    logic [31:0] dres;
    bit iter;

    vecs[0]  = '{"add",      4'b0000, 32'd7,        32'd5,        32'd12};
    vecs[1]  = '{"sub_zero", 4'b0001, 32'd5,        32'd5,        32'd0};
    vecs[2]  = '{"sub_wrap", 4'b0001, 32'd3,        32'd5,        32'hFFFF_FFFE};
    vecs[3]  = '{"and",      4'b0010, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234};
    vecs[4]  = '{"or",       4'b0011, 32'hF000_0001, 32'h0000_0100, 32'hF000_0101};
    vecs[5]  = '{"xor",      4'b0100, 32'hFFFF_0000, 32'hF0F0_F0F0, 32'h0F0F_F0F0};
    vecs[6]  = '{"slt",      4'b0101, 32'hFFFF_FFFF, 32'd1,        32'd1};
    vecs[7]  = '{"sltu",     4'b0110, 32'hFFFF_FFFF, 32'd1,        32'd0};
    vecs[8]  = '{"sll",      4'b0111, 32'd1,        32'd31,       32'h8000_0000};
    vecs[9]  = '{"srl",      4'b1000, 32'h8000_0000, 32'h0000_0104, 32'h0800_0000};
    vecs[10] = '{"sra",      4'b1001, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000};
    vecs[11] = '{"illegal",  4'b1110, 32'd7,        32'd5,        32'd0};
    vecs[12] = '{"mul",      4'b1010, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFE};
    vecs[13] = '{"mulhu",    4'b1011, 32'hFFFF_FFFF, 32'd2,        32'd1};
    vecs[14] = '{"divu",     4'b1100, 32'd100,      32'd7,        32'd14};
    vecs[15] = '{"remu",     4'b1101, 32'd100,      32'd7,        32'd2};
    vecs[16] = '{"divu_z",   4'b1100, 32'd9,        32'd0,        32'hFFFF_FFFF};
    vecs[17] = '{"remu_z",   4'b1101, 32'd9,        32'd0,        32'd9};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_res", ULAResult, 0);
    check("rst_z", Z, 1);

    foreach (vecs[i]) begin
      iter = (vecs[i].op >= 4'b1010) && (vecs[i].op <= 4'b1101);
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc);
      check({vecs[i].name, "_res"}, ULAResult, vecs[i].exp);
      check({vecs[i].name, "_z"}, Z, vecs[i].exp == 0);
      check({vecs[i].name, "_lat"}, lat, iter ? 33 : 1);
      check({vecs[i].name, "_busy"}, bc, iter ? 32 : 0);
      check({vecs[i].name, "_busy_at_done"}, busy, 0);
      @(negedge clk);
      check({vecs[i].name, "_done_drop"}, done, 0);
      check({vecs[i].name, "_hold"}, ULAResult, vecs[i].exp);
    end

    // start while busy plus operand change must not disturb an in-flight divide
    @(negedge clk);
    start = 1'b1; ULAControl = 4'b1100; SrcA = 32'd100; SrcB = 32'd7;
    ndone = 0; dcyc = 0; dres = '0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (done) begin ndone++; dcyc = cyc; dres = ULAResult; end
      if (cyc == 1) start = 1'b0;
      if (cyc == 10) begin start = 1'b1; ULAControl = 4'b0000; SrcA = 32'd0; end
      if (cyc == 11) start = 1'b0;
    end
    check("ign_ndone", ndone, 1);
    check("ign_cycle", dcyc, 33);
    check("ign_res", dres, 32'd14);

    // reset in the middle of a multiply
    @(negedge clk);
    start = 1'b1; ULAControl = 4'b1010; SrcA = 32'd3; SrcB = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rmid_busy", busy, 0);
    check("rmid_done", done, 0);
    check("rmid_res", ULAResult, 0);
    check("rmid_z", Z, 1);
    reset = 1'b0;
    ndone = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("rmid_no_done", ndone, 0);

    // back-to-back single-cycle ops: start in the done cycle
    @(negedge clk);
    start = 1'b1; ULAControl = 4'b0010; SrcA = 32'hF0; SrcB = 32'h3C;
    @(negedge clk);
    check("b2b_done1", done, 1);
    check("b2b_res1", ULAResult, 32'h30);
    ULAControl = 4'b0011; SrcA = 32'h01; SrcB = 32'h02;
    @(negedge clk);
    start = 1'b0;
    check("b2b_done2", done, 1);
    check("b2b_res2", ULAResult, 32'h03);
    check("b2b_busy", busy, 0);
    @(negedge clk);
    check("b2b_done3", done, 0);
    check("b2b_hold", ULAResult, 32'h03);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ula_multiciclo.md
Name: ula_multiciclo

Overview:
Parametrised successor of the datapath ALU: registered-output ALU adding XOR, signed/unsigned compare, shifts, zero flag, and iterative multiply/divide. Sits in the multicycle datapath between register-file read (SrcA) and ALUSrc mux (SrcB). Operation launched by a start pulse, completion signalled by a one-cycle done pulse. Control FSM stalls while busy=1.

Parameters:
WIDTH, 32, operand/result width in bits (≥8, power of two)
SHW, $clog2(WIDTH), shift-amount width (derived, not overridable)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  launch operation; sampled only when busy=0
ULAControl  input  4  operation code, sampled with start
SrcA  input  WIDTH  operand A, sampled with start
SrcB  input  WIDTH  operand B, sampled with start
busy  output  1  high from the cycle after accepted start until done
done  output  1  one-cycle pulse, result valid
ULAResult  output  WIDTH  registered result, held until next done
Z  output  1  ULAResult == 0, registered with ULAResult

Behaviour:
- Reset (sync): state IDLE, busy=0, done=0, ULAResult=0, Z=1, iteration counter=0. Reset mid-operation aborts; no done is produced.
- Opcodes: 0000 add; 0001 sub (A-B, two's complement, wraps); 0010 and; 0011 or; 0100 xor; 0101 slt signed (1/0); 0110 sltu unsigned; 0111 sll; 1000 srl; 1001 sra; 1010 mul low WIDTH bits; 1011 mulhu high WIDTH bits of unsigned product; 1100 divu quotient; 1101 remu remainder; 1110/1111 illegal -> result 0.
- Shifts use SrcB[SHW-1:0] only; upper bits ignored.
- Add/sub/mul wrap modulo 2^WIDTH; no overflow/carry output.
- FSM states IDLE, CALC.
  - IDLE + start: latch opcode/operands.
    - Single-cycle op (0000–1001, 1110, 1111): result written at next edge, done=1 in cycle 1, stays IDLE, busy never asserts.
    - Iterative op (1010–1101): go CALC, busy=1.
  - CALC: one shift-add (mul) or restoring-subtract (div) step per cycle. Counter 0..WIDTH-1. After WIDTH steps, result/Z register, done=1, busy=0, back to IDLE.
  - Latency start->done: 1 cycle single, WIDTH+1 cycles iterative (33 at WIDTH=32).
- start while busy=1: ignored, no queueing, operands not re-sampled.
- start in the done cycle: accepted (FSM is IDLE); back-to-back single-cycle ops give done every cycle.
- Operand/opcode changes after start: no effect on the in-flight result.
- Division by zero: divu -> all ones (2^WIDTH-1), remu -> SrcA. Still takes WIDTH+1 cycles; no exception.
- ULAResult/Z change only on the done cycle or on reset. Held otherwise.
- done is never high on two consecutive cycles except for back-to-back single-cycle ops.

Test Plan:
- Reset then add: reset 2 cycles; start, op 0000, A=7, B=5 -> cycle 1: done=1, ULAResult=12, Z=0, busy=0 throughout; before start: ULAResult=0, Z=1.
- Sub/compare/shift: sub A=5, B=5 -> 0, Z=1. slt A=0xFFFFFFFF, B=1 -> 1. sltu same operands -> 0. sra A=0x80000000, B=0x24 -> 0xF8000000 (amount 4). sll A=1, B=31 -> 0x80000000.
- Multiply: mul A=0xFFFFFFFF, B=2 -> done at cycle 33, ULAResult=0xFFFFFFFE. mulhu same operands -> 1. busy=1 in cycles 1–32.
- Divide incl. by zero: divu 100/7 -> 14; remu -> 2. divu 9/0 -> 0xFFFFFFFF; remu 9/0 -> 9. Each done at cycle 33.
- Ignored start and changing operands: during a divu 100/7, pulse start with op 0000 at cycle 10 and change SrcA to 0 -> still single done at cycle 33 with 14, no extra done.
- Reset mid-op and back-to-back: reset at cycle 5 of a mul -> next cycle busy=0, ULAResult=0, Z=1, no done. Then start in the done cycle of an and (0xF0 & 0x3C=0x30) with or 0x01|0x02 -> done on two consecutive cycles, results 0x30 then 0x03.
